wakeup_sched: RTL

Per-FU wakeup/select scheduler that owns the wakeup entry array between Dispatch and the functional units. It allocates a free column in the target FU's entry row and records the entry's source dependencies as entry locations. It selects one ready entry per FU per cycle using round-robin, then counts down the issued entry's latency. It broadcasts a wakeup on that location to clear dependents and frees the entry.

---
 rtl/wakeup_sched_if.sv | 38 +++
 rtl/wakeup_sched.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/wakeup_sched_if.sv
// Dispatch, issue and wakeup signals shared between the scheduler and its environment.
// The master side drives dispatch, flush and FU-ready; the slave side is the scheduler.
interface wakeup_sched_if #(
    parameter int NUM_FUS  = 4,
    parameter int NUM_COLS = 4,
    parameter int LAT_W    = 3
);
    localparam int FU_W  = $clog2(NUM_FUS);
    localparam int COL_W = $clog2(NUM_COLS);
    localparam int LOC_W = FU_W + COL_W;

    logic                         flush;
    logic                         disp_valid;
    logic [FU_W-1:0]              disp_fu;
    logic [LAT_W-1:0]             disp_latency;
    logic                         src1_dp_en;
    logic                         src2_dp_en;
    logic [LOC_W-1:0]             src1_dp_loc;
    logic [LOC_W-1:0]             src2_dp_loc;
    logic                         disp_ready;
    logic [LOC_W-1:0]             disp_loc;
    logic [NUM_FUS-1:0]           issue_valid;
    logic [NUM_FUS*COL_W-1:0]     issue_col;
    logic [NUM_FUS-1:0]           issue_ready;
    logic [NUM_FUS*NUM_COLS-1:0]  wake_vec;

    modport master (
        output flush, disp_valid, disp_fu, disp_latency,
               src1_dp_en, src2_dp_en, src1_dp_loc, src2_dp_loc, issue_ready,
        input  disp_ready, disp_loc, issue_valid, issue_col, wake_vec
    );

    modport slave (
        input  flush, disp_valid, disp_fu, disp_latency,
               src1_dp_en, src2_dp_en, src1_dp_loc, src2_dp_loc, issue_ready,
        output disp_ready, disp_loc, issue_valid, issue_col, wake_vec
    );
endinterface

// File: rtl/wakeup_sched.sv
// Per-FU wakeup/select scheduler: allocates entries, tracks source dependencies,
// selects one ready entry per FU round-robin and broadcasts wakeup when latency expires.
module wakeup_sched #(
    parameter int NUM_FUS  = 4,
    parameter int NUM_COLS = 4,
    parameter int LAT_W    = 3
) (
    input logic           clk,
    input logic           rst,
    wakeup_sched_if.slave bus
);
    localparam int FU_W  = $clog2(NUM_FUS);
    localparam int COL_W = $clog2(NUM_COLS);
    localparam int LOC_W = FU_W + COL_W;
    localparam int NENT  = NUM_FUS * NUM_COLS;

    localparam logic [1:0] ST_FREE   = 2'd0;
    localparam logic [1:0] ST_WAIT   = 2'd1;
    localparam logic [1:0] ST_READY  = 2'd2;
    localparam logic [1:0] ST_ISSUED = 2'd3;

    logic [1:0]       state_q [NENT];
    logic [1:0]       state_d [NENT];
    logic             pend1_q [NENT];
    logic             pend1_d [NENT];
    logic             pend2_q [NENT];
    logic             pend2_d [NENT];
    logic [LOC_W-1:0] src1_q  [NENT];
    logic [LOC_W-1:0] src1_d  [NENT];
    logic [LOC_W-1:0] src2_q  [NENT];
    logic [LOC_W-1:0] src2_d  [NENT];
    logic [LAT_W-1:0] lat_q   [NENT];
    logic [LAT_W-1:0] lat_d   [NENT];
    logic [LAT_W-1:0] cnt_q   [NENT];
    logic [LAT_W-1:0] cnt_d   [NENT];
    logic [COL_W-1:0] rr_q    [NUM_FUS];
    logic [COL_W-1:0] rr_d    [NUM_FUS];

    logic [NENT-1:0]    wake;
    logic               allocFound;
    logic [COL_W-1:0]   allocCol;
    logic [LOC_W-1:0]   allocLoc;
    logic               dispPend1;
    logic               dispPend2;
    logic [NUM_FUS-1:0] selValid;
    logic [COL_W-1:0]   selCol [NUM_FUS];

    // Wakeup fires on the last countdown cycle; flush suppresses it.
    always_comb begin
        for (int e = 0; e < NENT; e++) begin
            wake[e] = ~bus.flush & (state_q[e] == ST_ISSUED) & (cnt_q[e] == LAT_W'(1));
        end
    end

    always_comb begin
        allocFound = 1'b0;
        allocCol   = '0;
        for (int c = NUM_COLS - 1; c >= 0; c--) begin
            if (state_q[{bus.disp_fu, COL_W'(c)}] == ST_FREE) begin
                allocFound = 1'b1;
                allocCol   = COL_W'(c);
            end
        end
        allocLoc  = {bus.disp_fu, allocCol};
        dispPend1 = bus.src1_dp_en & (state_q[bus.src1_dp_loc] != ST_FREE) & ~wake[bus.src1_dp_loc];
        dispPend2 = bus.src2_dp_en & (state_q[bus.src2_dp_loc] != ST_FREE) & ~wake[bus.src2_dp_loc];
    end

    always_comb begin
        for (int f = 0; f < NUM_FUS; f++) begin
            selValid[f] = 1'b0;
            selCol[f]   = '0;
            for (int k = 0; k < NUM_COLS; k++) begin
                if (!selValid[f] &&
                    state_q[{FU_W'(f), COL_W'(rr_q[f] + COL_W'(k))}] == ST_READY) begin
                    selValid[f] = 1'b1;
                    selCol[f]   = COL_W'(rr_q[f] + COL_W'(k));
                end
            end
        end
    end

    always_comb begin
        bus.issue_col = '0;
        for (int f = 0; f < NUM_FUS; f++) begin
            bus.issue_col[f*COL_W +: COL_W] = selCol[f];
        end
    end

    assign bus.disp_ready  = allocFound;
    assign bus.disp_loc    = allocLoc;
    assign bus.issue_valid = selValid;
    assign bus.wake_vec    = wake;

    // Entries only ever see one event per cycle, so the per-state updates never collide.
    always_comb begin
        state_d = state_q;
        pend1_d = pend1_q;
        pend2_d = pend2_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        lat_d   = lat_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        for (int e = 0; e < NENT; e++) begin
            if (state_q[e] == ST_WAIT) begin
                pend1_d[e] = pend1_q[e] & ~wake[src1_q[e]];
                pend2_d[e] = pend2_q[e] & ~wake[src2_q[e]];
                if (!pend1_d[e] && !pend2_d[e]) begin
                    state_d[e] = ST_READY;
                end
            end else if (state_q[e] == ST_ISSUED) begin
                if (cnt_q[e] == LAT_W'(1)) begin
                    state_d[e] = ST_FREE;
                end else begin
                    cnt_d[e] = cnt_q[e] - LAT_W'(1);
                end
            end
        end
        for (int f = 0; f < NUM_FUS; f++) begin
            if (selValid[f] && bus.issue_ready[f]) begin
                state_d[{FU_W'(f), selCol[f]}] = ST_ISSUED;
                cnt_d[{FU_W'(f), selCol[f]}]   = lat_q[{FU_W'(f), selCol[f]}];
                rr_d[f]                        = selCol[f] + COL_W'(1);
            end
        end
        if (bus.disp_valid && allocFound) begin
            state_d[allocLoc] = (dispPend1 || dispPend2) ? ST_WAIT : ST_READY;
            pend1_d[allocLoc] = dispPend1;
            pend2_d[allocLoc] = dispPend2;
            src1_d[allocLoc]  = bus.src1_dp_loc;
            src2_d[allocLoc]  = bus.src2_dp_loc;
            lat_d[allocLoc]   = (bus.disp_latency == '0) ? LAT_W'(1) : bus.disp_latency;
        end
        if (bus.flush) begin
            for (int e = 0; e < NENT; e++) begin
                state_d[e] = ST_FREE;
            end
            for (int f = 0; f < NUM_FUS; f++) begin
                rr_d[f] = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int e = 0; e < NENT; e++) begin
                state_q[e] <= ST_FREE;
                pend1_q[e] <= 1'b0;
                pend2_q[e] <= 1'b0;
                src1_q[e]  <= '0;
                src2_q[e]  <= '0;
                lat_q[e]   <= '0;
                cnt_q[e]   <= '0;
            end
            for (int f = 0; f < NUM_FUS; f++) begin
                rr_q[f] <= '0;
            end
        end else begin
            state_q <= state_d;
            pend1_q <= pend1_d;
            pend2_q <= pend2_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            lat_q   <= lat_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end
endmodule
